// File: rtl/puf_uart_tx.sv
// Two-frame UART transmitter for the 16-bit PUF response (low byte first, 8N1).
// Define PUF_UART_PARITY_EN to build 8E1 frames with an even-parity bit.
module puf_uart_tx #(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 9600
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_tx,
   input  logic [15:0] seq,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef PUF_UART_PARITY_EN
      PARITY,
`endif
      STOP
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic             sel_q, sel_d;
   logic [15:0]      word_q, word_d;
   logic             s1_q, s2_q, s3_q;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             baud_tick;
   logic [7:0]       nxt_byte;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= start_tx;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sel_q   <= 1'b0;
         word_q  <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sel_q   <= sel_d;
         word_q  <= word_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_d     = bit_q;
      sel_d     = sel_q;
      word_d    = word_q;
      done_d    = 1'b0;
      baud_tick = (cnt_q == CNT_LAST);
      cnt_d     = baud_tick ? '0 : cnt_q + 1'b1;

      // Every state change happens on a baud tick, so the wrap to 0 doubles as the entry clear.
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (s2_q && !s3_q) begin
               state_d = START;
               word_d  = seq;
               sel_d   = 1'b0;
            end
         end
         START: begin
            if (baud_tick) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (baud_tick) begin
               if (bit_q == 3'd7) begin
`ifdef PUF_UART_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
`ifdef PUF_UART_PARITY_EN
         PARITY: begin
            if (baud_tick) state_d = STOP;
         end
`endif
         STOP: begin
            if (baud_tick) begin
               if (!sel_q) begin
                  sel_d   = 1'b1;
                  state_d = START;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level is registered from the next state so tx is a clean flop output.
      nxt_byte = sel_d ? word_d[15:8] : word_d[7:0];
      tx_d     = 1'b1;
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = nxt_byte[bit_d];
`ifdef PUF_UART_PARITY_EN
         PARITY:  tx_d = ^nxt_byte;
`endif
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_puf_uart_tx.sv
// Scoreboard bench for puf_uart_tx: stimulus queues expected bytes/timing, a UART
// decoder and line monitor on the falling edge pop and compare.
module tb_puf_uart_tx;

   localparam int CPB  = 10;
   localparam int HALF = CPB / 2;
`ifdef PUF_UART_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME_CYC = 2 * NB * CPB;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_tx;
   logic [15:0] seq;
   logic        tx, busy, done;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [7:0] exp_q[$];
   int         rise_q[$];

   puf_uart_tx #(
      .CLK_FREQ(100_000_000),
      .BAUD    (10_000_000)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start_tx(start_tx),
      .seq     (seq),
      .tx      (tx),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- monitor: UART decoder + busy/done timing ----------------
   bit         rx_on = 0;
   int         rx_t;
   logic [7:0] rx_byte;
   logic       rx_par;
   logic       prev_busy = 0;
   int         blen = 0;

   always @(negedge clk) begin
      if (rst) begin
         rx_on     = 0;
         prev_busy = 0;
         blen      = 0;
      end else begin
         if (!rx_on) begin
            if (tx == 1'b0) begin
               rx_on = 1;
               rx_t  = 0;
            end
         end else begin
            rx_t++;
            if (rx_t == HALF) begin
               check("start_bit", 32'(tx), 32'd0);
            end else if (rx_t > HALF && (rx_t - HALF) % CPB == 0) begin
               int k;
               k = (rx_t - HALF) / CPB;
               if (k <= 8) begin
                  rx_byte[k-1] = tx;
               end else if (k < NB - 1) begin
                  rx_par = tx;
               end else begin
                  logic [7:0] e;
                  check("stop_bit", 32'(tx), 32'd1);
                  if (exp_q.size() == 0) begin
                     n_cmp++;
                     n_bad++;
                     $display("FAIL unexpected_frame: got 0x%0h, expected no frame", rx_byte);
                  end else begin
                     e = exp_q.pop_front();
                     check("frame_byte", 32'(rx_byte), 32'(e));
`ifdef PUF_UART_PARITY_EN
                     check("parity_bit", 32'(rx_par), 32'($countones(e) % 2));
`endif
                  end
                  rx_on = 0;
               end
            end
         end

         if (!prev_busy && busy) begin
            if (rise_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL busy_rise: got rise at cycle %0d, expected none", cyc);
            end else begin
               check("busy_rise_cycle", 32'(cyc), 32'(rise_q.pop_front()));
            end
            blen = 1;
         end else if (busy) begin
            blen++;
         end

         if (prev_busy && !busy) begin
            check("busy_len", 32'(blen), 32'(FRAME_CYC));
            check("done_at_end", 32'(done), 32'd1);
         end else if (done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_stray: got done=1, expected 0 (cycle %0d)", cyc);
         end
         prev_busy = busy;
      end
   end

   // ---------------- stimulus ----------------
   // Start edge driven just after edge c: synchronizer accepts, busy/start bit at edge c+3.
   task automatic send(input logic [15:0] w, input bit hold, input bit poke, input int glitch_at);
      @(posedge clk);
      #1;
      seq      = w;
      start_tx = 1'b1;
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
      rise_q.push_back(cyc + 3);
      for (int t = 1; t <= FRAME_CYC + 30; t++) begin
         @(posedge clk);
         #1;
         if (t == 1 && !hold) start_tx = 1'b0;
         if (poke && t == 3) seq = 16'($urandom);
         if (glitch_at > 0) begin
            if (t == glitch_at)             start_tx = 1'b0;
            if (t == glitch_at + 3)         start_tx = 1'b1;
            if (t == glitch_at + 6 && !hold) start_tx = 1'b0;
         end
         if (t == FRAME_CYC + 25) begin
            check("idle_tx", 32'(tx), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
         end
      end
      check("bytes_drained", 32'(exp_q.size()), 32'd0);
      start_tx = 1'b0;
      repeat (6) @(posedge clk);
   endtask

   initial begin
      rst      = 1'b1;
      start_tx = 1'b0;
      seq      = '0;
      #12;
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(posedge clk);

      send(16'hA53C, 1'b0, 1'b0, 0);
      send(16'hA53C, 1'b1, 1'b0, 0);
      send(16'hA53C, 1'b0, 1'b0, 50);

      // Abort during byte-0 data bits (all zero, so a live frame would hold tx low).
      @(posedge clk);
      #1;
      seq      = 16'h1300;
      start_tx = 1'b1;
      rise_q.push_back(cyc + 3);
      @(posedge clk);
      #1 start_tx = 1'b0;
      repeat (2 + 4 * CPB) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_tx", 32'(tx), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);

      send(16'h00FF, 1'b0, 1'b0, 0);
      send(16'h0107, 1'b0, 1'b0, 0);

      // seq changes one cycle after acceptance of BEEF
      @(posedge clk);
      #1;
      seq      = 16'hBEEF;
      start_tx = 1'b1;
      exp_q.push_back(8'hEF);
      exp_q.push_back(8'hBE);
      rise_q.push_back(cyc + 3);
      @(posedge clk);
      #1 start_tx = 1'b0;
      repeat (2) @(posedge clk);
      #1 seq = 16'h1234;
      repeat (FRAME_CYC + 10) @(posedge clk);
      check("beef_drained", 32'(exp_q.size()), 32'd0);
      repeat (6) @(posedge clk);

      for (int i = 0; i < 10; i++) begin
         logic [15:0] w;
         bit          h, p;
         int          g;
         w = 16'($urandom);
         h = 1'($urandom);
         p = 1'($urandom);
         g = ($urandom % 2 == 1) ? int'($urandom_range(20, FRAME_CYC - 20)) : 0;
         send(w, h, p, g);
      end

      repeat (20) @(posedge clk);
      check("final_bytes_empty", 32'(exp_q.size()), 32'd0);
      check("final_rise_empty", 32'(rise_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/puf_uart_tx.md
# puf_uart_tx

Serial transmitter for the PUF response word. It watches the `start_tx` level that the PUF capture logic raises once the 16-bit response sequence is complete, and latches that sequence. It then sends the sequence as two UART frames (low byte first) on a single `tx` line to the board's USB-UART bridge. It runs on the 100 MHz board clock and is the off-chip end of the response path.

## Interface
- `CLK_FREQ`, 100_000_000: input clock frequency in Hz.
- `BAUD`, 9600: serial bit rate. `CLKS_PER_BIT = CLK_FREQ / BAUD` (integer division). Legal only if `CLKS_PER_BIT >= 2`.

- `clk`  input  1  board clock. All logic is on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start_tx`  input  1  level request from the PUF capture logic. Only its rising edge starts a transmission.
- `seq`  input  16  PUF response word. Sampled only when a start is accepted.
- `tx`  output  1  UART line. Idle high.
- `busy`  output  1  high from start acceptance until the end of the last stop bit.
- `done`  output  1  one-cycle pulse when the second frame completes.

## Operation
- Reset values: `tx=1`, `busy=0`, `done=0`, FSM in `IDLE`, byte select 0, synchronizer flops 0.
- `start_tx` passes through a 2-flop synchronizer (`s1`, `s2`) plus a history flop `s3`.
- A start is accepted when `s2 & ~s3` and the FSM is in `IDLE`. On acceptance: `seq` is latched into `word`, byte select is cleared, and `busy` is set.
- A rising edge seen while `busy` is dropped. It is not queued.
- A `start_tx` held high causes exactly one transmission. Dropping it and raising it again causes another.
- States:
  - `IDLE`: `tx=1`. On acceptance, go to `START`.
  - `START`: `tx=0` for `CLKS_PER_BIT` cycles, then go to `DATA` with bit index 0.
  - `DATA`: `tx` = current byte bit[index], LSB first. Each bit lasts `CLKS_PER_BIT` cycles. After index 7, go to `PARITY` if enabled, else `STOP`.
  - `PARITY` (only with the macro): `tx` = even parity of the current byte for `CLKS_PER_BIT` cycles, then go to `STOP`.
  - `STOP`: `tx=1` for `CLKS_PER_BIT` cycles. Then:
    - If byte select is 0: set it to 1 and go to `START` with no idle gap.
    - Otherwise: go to `IDLE`, clear `busy`, and pulse `done`.
- Current byte is `word[7:0]` when byte select is 0, and `word[15:8]` when it is 1.
- Baud counter: counts 0 to `CLKS_PER_BIT-1`, then wraps to 0 and advances the bit or state. It is cleared on every state entry.
- Changes on `seq` after acceptance have no effect on the frame in progress.
- `rst` asserted mid-frame returns every output to its reset value immediately, with no clock needed. The partial frame is abandoned. After release, a new start needs a fresh rising edge through the synchronizer.

## Timing
- Latency from `start_tx` to the start bit:
  - `start_tx` is first high at edge N.
  - `s2` is high at N+1 and acceptance occurs there.
  - `tx` falls and `busy` rises at N+2.
- Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Frame length is 10 bits, or 11 with parity.
- Full transmission: `busy` stays high for 20·`CLKS_PER_BIT` cycles, or 22·`CLKS_PER_BIT` with parity.
- `done` is high for one cycle, in the same cycle `busy` falls and the FSM re-enters `IDLE`.
- The start bit of byte 1 follows the last stop-bit cycle of byte 0 directly.

## Configuration
- `PUF_UART_PARITY_EN` defined:
  - `PARITY` state is compiled in.
  - Frame is 8E1 (even parity: the count of ones across data plus parity is even).
- Not defined:
  - Frame is 8N1.
  - No parity logic or parity state exists.

## Test plan
All scenarios use `CLK_FREQ=100_000_000`, `BAUD=10_000_000` (`CLKS_PER_BIT=10`), no parity unless stated.
- `seq=16'hA53C`, pulse `start_tx` ->
  - bench UART decoder receives 0x3C then 0xA5;
  - `busy` is high for 200 cycles;
  - one `done` pulse.
- `start_tx` held high through and after completion -> exactly one two-byte transmission; `tx` stays at 1 afterwards.
- Second `start_tx` rising edge at cycle 50 of a transmission -> ignored; only 0x3C, 0xA5 are sent, and no extra frame follows.
- `rst` asserted during the `DATA` bits of byte 0 -> `tx=1`, `busy=0`, `done=0` at once. A new edge with `seq=16'h00FF` then yields 0xFF, 0x00.
- With `PUF_UART_PARITY_EN`, `seq=16'h0107` -> frames carry 0x07 with parity bit 1 and 0x01 with parity bit 1; `busy` is high for 220 cycles.
- `seq` changed to 16'h1234 one cycle after acceptance of 16'hBEEF -> 0xEF, 0xBE are sent.
